// File: rtl/cpu_core.sv
// Minimal 16-bit accumulator CPU: eight registers, 11-bit PC, single-cycle execute
// from an external instruction memory, with LED and 8x8 matrix scan outputs.
module cpu_core #(
    parameter int ROW_SEL_LSB = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  btn,
    input  logic [23:0] counter,
    input  logic [15:0] dout,
    output logic [10:0] adr,
    output logic [3:0]  led,
    output logic [7:0]  col,
    output logic [7:0]  row
);

    logic [10:0] pc_q;
    logic [10:0] pc_d;
    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];

    logic [2:0]  rrr;
    logic [15:0] src;
    logic [15:0] acc;
    logic [10:0] target;
    logic [2:0]  row_sel;
    logic        counter_unused;

    assign rrr    = dout[2:0];
    assign src    = regs_q[rrr];
    assign acc    = regs_q[0];
    assign target = {dout[14:8], dout[3:0]};

    // Operands always come from pre-edge register values; SWAP with rrr=0
    // writes r0 back onto itself.
    always_comb begin
        pc_d = pc_q + 11'd1;
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end
        casez (dout[7:0])
            8'b1010_????: regs_d[0] = {4'b0000, dout[15:8], dout[3:0]};
            8'b1001_????: pc_d = target;
            8'b1011_????: begin
                if (acc != 16'd0) begin
                    pc_d = target;
                end
            end
            8'b0100_0???: regs_d[rrr] = acc;
            8'b0100_1???: regs_d[0]   = acc + src;
            8'b0101_0???: regs_d[rrr] = src + 16'd1;
            8'b0101_1???: regs_d[rrr] = src - 16'd1;
            8'b0110_0???: regs_d[rrr] = {12'd0, btn};
            8'b0110_1???: begin
                regs_d[0]   = src;
                regs_d[rrr] = acc;
            end
            8'b0111_0???: regs_d[rrr] = {src[0], src[15:1]};
            8'b0111_1???: regs_d[rrr] = {src[14:0], src[15]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_regs
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    // Only a 3-bit slice of the counter drives the scan; the rest is ignored.
    assign counter_unused = ^counter;
    assign row_sel        = counter[ROW_SEL_LSB+2:ROW_SEL_LSB];

    assign adr = pc_q;
    assign led = acc[3:0];
    assign row = 8'b0000_0001 << row_sel;
    assign col = regs_q[row_sel][7:0];

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: acts as the instruction memory, checks reset,
// a looping program, asynchronous reset, and a table of single-instruction steps.
module tb_cpu_core;

    logic        clk;
    logic        reset;
    logic [3:0]  btn;
    logic [23:0] counter;
    logic [15:0] dout;
    logic [10:0] adr;
    logic [3:0]  led;
    logic [7:0]  col;
    logic [7:0]  row;

    logic [15:0] mem [0:2047];

    int checks;
    int failures;

    cpu_core #(.ROW_SEL_LSB(13)) dut (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn),
        .counter (counter),
        .dout    (dout),
        .adr     (adr),
        .led     (led),
        .col     (col),
        .row     (row)
    );

    assign dout = mem[adr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  btn;
        logic [2:0]  k;
        logic [10:0] exp_adr;
        logic [3:0]  exp_led;
        logic [7:0]  exp_col;
    } vec_t;

    vec_t vecs [33];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_row(input logic [2:0] k);
        logic [23:0] cnt;
        cnt = 24'($urandom());
        cnt[15:13] = k;
        counter = cnt;
    endtask

    logic [10:0] loop_adr [8];
    logic [7:0]  loop_r0  [8];
    logic [10:0] cur_pc;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        btn      = 4'h0;
        counter  = 24'h0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;

        vecs[0]  = '{16'h80A0, 4'h0, 3'd0, 11'h001, 4'h0, 8'h00};
        vecs[1]  = '{16'h0078, 4'h0, 3'd0, 11'h002, 4'h0, 8'h00};
        vecs[2]  = '{16'h0078, 4'h0, 3'd0, 11'h003, 4'h0, 8'h00};
        vecs[3]  = '{16'h0078, 4'h0, 3'd0, 11'h004, 4'h0, 8'h00};
        vecs[4]  = '{16'h0078, 4'h0, 3'd0, 11'h005, 4'h0, 8'h00};
        vecs[5]  = '{16'h0078, 4'h0, 3'd0, 11'h006, 4'h1, 8'h01};
        vecs[6]  = '{16'h0070, 4'h0, 3'd0, 11'h007, 4'h0, 8'h00};
        vecs[7]  = '{16'h0078, 4'h0, 3'd0, 11'h008, 4'h1, 8'h01};
        vecs[8]  = '{16'h0063, 4'hA, 3'd3, 11'h009, 4'h1, 8'h0A};
        vecs[9]  = '{16'h00A5, 4'h0, 3'd0, 11'h00A, 4'h5, 8'h05};
        vecs[10] = '{16'h004B, 4'h0, 3'd0, 11'h00B, 4'hF, 8'h0F};
        vecs[11] = '{16'h0042, 4'h0, 3'd2, 11'h00C, 4'hF, 8'h0F};
        vecs[12] = '{16'h0AA5, 4'h0, 3'd0, 11'h00D, 4'h5, 8'hA5};
        vecs[13] = '{16'h0042, 4'h0, 3'd2, 11'h00E, 4'h5, 8'hA5};
        vecs[14] = '{16'h00A3, 4'h0, 3'd0, 11'h00F, 4'h3, 8'h03};
        vecs[15] = '{16'h006A, 4'h0, 3'd2, 11'h010, 4'h5, 8'h03};
        vecs[16] = '{16'h0052, 4'h0, 3'd2, 11'h011, 4'h5, 8'h04};
        vecs[17] = '{16'h005A, 4'h0, 3'd2, 11'h012, 4'h5, 8'h03};
        vecs[18] = '{16'h0059, 4'h0, 3'd1, 11'h013, 4'h5, 8'hFF};
        vecs[19] = '{16'h0051, 4'h0, 3'd1, 11'h014, 4'h5, 8'h00};
        vecs[20] = '{16'h0068, 4'h0, 3'd0, 11'h015, 4'h5, 8'hA5};
        vecs[21] = '{16'h00FF, 4'h0, 3'd0, 11'h016, 4'h5, 8'hA5};
        vecs[22] = '{16'h0000, 4'h0, 3'd0, 11'h017, 4'h5, 8'hA5};
        vecs[23] = '{16'h12B3, 4'h0, 3'd0, 11'h123, 4'h5, 8'hA5};
        vecs[24] = '{16'h9291, 4'h0, 3'd0, 11'h121, 4'h5, 8'hA5};
        vecs[25] = '{16'h00A2, 4'h0, 3'd0, 11'h122, 4'h2, 8'h02};
        vecs[26] = '{16'h0069, 4'h0, 3'd1, 11'h123, 4'h0, 8'h02};
        vecs[27] = '{16'h0059, 4'h0, 3'd1, 11'h124, 4'h0, 8'h01};
        vecs[28] = '{16'h0069, 4'h0, 3'd1, 11'h125, 4'h1, 8'h00};
        vecs[29] = '{16'h0058, 4'h0, 3'd0, 11'h126, 4'h0, 8'h00};
        vecs[30] = '{16'h12B3, 4'h0, 3'd0, 11'h127, 4'h0, 8'h00};
        vecs[31] = '{16'h7F9F, 4'h0, 3'd0, 11'h7FF, 4'h0, 8'h00};
        vecs[32] = '{16'h0000, 4'h0, 3'd0, 11'h000, 4'h0, 8'h00};

        loop_adr = '{11'd1, 11'd2, 11'd1, 11'd2, 11'd1, 11'd2, 11'd1, 11'd2};
        loop_r0  = '{8'h01, 8'h02, 8'h02, 8'h04, 8'h04, 8'h08, 8'h08, 8'h10};

        // Reset held for 10 clocks
        mem[0] = 16'h00A1;
        mem[1] = 16'h0078;
        mem[2] = 16'h0091;
        set_row(3'd0);
        repeat (10) @(negedge clk);
        check("reset_adr", 32'(adr), 32'h0);
        check("reset_led", 32'(led), 32'h0);
        check("reset_col", 32'(col), 32'h0);
        check("reset_row", 32'(row), 32'h01);

        // Looping program MVI 1 / LROTATE r0 / JMP 1
        reset = 1'b1;
        check("loop_adr_start", 32'(adr), 32'h0);
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("loop_adr_%0d", e), 32'(adr), 32'(loop_adr[e]));
            check($sformatf("loop_led_%0d", e), 32'(led), 32'(loop_r0[e][3:0]));
            check($sformatf("loop_col_%0d", e), 32'(col), 32'(loop_r0[e]));
            $display("loop step %0d adr=%0h led=%b col=%02h", e, adr, led, col);
        end

        // Rerun, then drop reset between clock edges with r0=8, adr=2
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_async_adr", 32'(adr), 32'h2);
        check("pre_async_led", 32'(led), 32'h8);
        #2;
        reset = 1'b0;
        #1;
        check("async_adr", 32'(adr), 32'h0);
        check("async_led", 32'(led), 32'h0);
        check("async_col", 32'(col), 32'h0);
        $display("async reset adr=%0h led=%b col=%02h", adr, led, col);

        // Table of single-instruction steps from a clean reset
        @(negedge clk);
        reset  = 1'b1;
        cur_pc = 11'd0;
        for (int v = 0; v < 33; v++) begin
            mem[cur_pc] = vecs[v].instr;
            btn         = vecs[v].btn;
            set_row(vecs[v].k);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_adr", v), 32'(adr), 32'(vecs[v].exp_adr));
            check($sformatf("vec%0d_led", v), 32'(led), 32'(vecs[v].exp_led));
            check($sformatf("vec%0d_col", v), 32'(col), 32'(vecs[v].exp_col));
            check($sformatf("vec%0d_row", v), 32'(row), 32'(8'h01 << vecs[v].k));
            $display("vec %0d instr=%04h adr=%03h led=%b row=%02h col=%02h",
                     v, vecs[v].instr, adr, led, row, col);
            cur_pc = vecs[v].exp_adr;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
